// File: rtl/rr_sched_4shared.sv
// rtl/rr_sched_4shared.sv - round-robin scheduler sharing one WIDTH-bit adder among four requesters
// Optional saturating add: define SCHED_SAT_EN.
module rr_sched_4shared #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] a2,
   input  logic [WIDTH-1:0] a3,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] b1,
   input  logic [WIDTH-1:0] b2,
   input  logic [WIDTH-1:0] b3,
   output logic [3:0]       gnt,
   output logic [WIDTH-1:0] y,
   output logic [3:0]       y_vld,
   output logic             busy
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] GRANT = 2'b01;
   localparam logic [1:0] EXEC  = 2'b10;
   localparam logic [1:0] WRITE = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       tag_q, tag_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] y_q, y_d;

   logic [1:0]       sel;
   logic [1:0]       idx;
   logic             found;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH-1:0] sum;

   // Circular priority search starting at ptr_q; the last served sits at the bottom.
   always_comb begin
      sel   = ptr_q;
      idx   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      case (tag_q)
         2'd0:    begin a_sel = a0; b_sel = b0; end
         2'd1:    begin a_sel = a1; b_sel = b1; end
         2'd2:    begin a_sel = a2; b_sel = b2; end
         default: begin a_sel = a3; b_sel = b3; end
      endcase
   end

`ifdef SCHED_SAT_EN
   logic [WIDTH:0] sum_ext;
   always_comb begin
      sum_ext = {1'b0, a_q} + {1'b0, b_q};
      sum     = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
   end
`else
   assign sum = a_q + b_q;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tag_d   = tag_q;
      a_d     = a_q;
      b_d     = b_q;
      y_d     = y_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               tag_d   = sel;
               state_d = GRANT;
            end
         end
         GRANT: begin
            a_d     = a_sel;
            b_d     = b_sel;
            ptr_d   = tag_q + 2'd1;
            state_d = EXEC;
         end
         EXEC: begin
            y_d     = sum;
            state_d = WRITE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         tag_q   <= 2'd0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tag_q   <= tag_d;
         a_q     <= a_d;
         b_q     <= b_d;
         y_q     <= y_d;
      end
   end

   // Handshake outputs come straight from registered state and tag.
   assign gnt   = (state_q == GRANT) ? (4'b0001 << tag_q) : 4'b0000;
   assign y_vld = (state_q == WRITE) ? (4'b0001 << tag_q) : 4'b0000;
   assign busy  = (state_q != IDLE);
   assign y     = y_q;

endmodule
